// File: rtl/nxn_game_engine.sv
// nxn_game_engine
//   N x N board, K-in-a-row two-player game core. Moves arrive over a
//   valid/ready handshake and are stored in a register board. Each accepted
//   move triggers a 4-cycle scan (horizontal, vertical, diagonal,
//   anti-diagonal) through the placed cell. A registered read port serves
//   the display.
//
//   Optional build macro: TURN_ENFORCE_EN
//     defined   - a move whose player differs from 'turn' is rejected
//     undefined - 'turn' is advisory only; either player may move
//
// Ports
//   clock, reset          clock, async active-low reset
//   new_game              synchronous clear of board and game state
//   move_valid/_player    move request, player 0 = P1, 1 = P2
//   move_row/_col         target cell
//   move_ready            high while IDLE
//   move_illegal          1-cycle pulse on a rejected move
//   result_valid          1-cycle pulse at the end of a scan
//   win/winner/draw       game result levels (winner 01 = P1, 10 = P2)
//   turn                  player expected next
//   move_count            occupied cells
//   rd_row/rd_col/rd_cell registered read port, 1-cycle latency
module nxn_game_engine #(
   parameter int N  = 3,
   parameter int K  = 3,
   parameter int AW = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          new_game,
   input  logic          move_valid,
   input  logic          move_player,
   input  logic [AW-1:0] move_row,
   input  logic [AW-1:0] move_col,
   output logic          move_ready,
   output logic          move_illegal,
   output logic          result_valid,
   output logic          win,
   output logic [1:0]    winner,
   output logic          draw,
   output logic          turn,
   output logic [7:0]    move_count,
   input  logic [AW-1:0] rd_row,
   input  logic [AW-1:0] rd_col,
   output logic [1:0]    rd_cell
);

   localparam int CELLS = N * N;
   localparam int IW    = $clog2(CELLS + 1);

   typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

   state_t                  state;
   logic [CELLS-1:0][1:0]   board;
   logic [AW-1:0]           pr, pc;     // latched placed cell
   logic [1:0]              pcode;      // latched player code
   logic [1:0]              dir;        // scan direction counter
   logic                    hit;        // sticky: some direction reached K

   // True when (r,c) is on the board and holds 'code'. Off-board cells
   // terminate a run, which is how the scan stops at the edge.
   function automatic logic cell_eq(input logic [CELLS-1:0][1:0] b,
                                    input int r, input int c,
                                    input logic [1:0] code);
      if (r < 0 || r >= N || c < 0 || c >= N) return 1'b0;
      return b[IW'(r * N + c)] == code;
   endfunction

   // ---------------- scan for the current direction ----------------
   int   scan_dr, scan_dc, scan_cnt;
   logic go_f, go_b, line_hit;

   always_comb begin
      scan_dr  = 0;
      scan_dc  = 1;
      scan_cnt = 1;               // the placed cell itself
      go_f     = 1'b1;
      go_b     = 1'b1;
      case (dir)
         2'd0:    begin scan_dr = 0; scan_dc = 1;  end
         2'd1:    begin scan_dr = 1; scan_dc = 0;  end
         2'd2:    begin scan_dr = 1; scan_dc = 1;  end
         default: begin scan_dr = 1; scan_dc = -1; end
      endcase
      // Walk outward both ways; each side stops at the first mismatch.
      for (int i = 1; i < K; i++) begin
         if (go_f && cell_eq(board, int'(pr) + i * scan_dr,
                             int'(pc) + i * scan_dc, pcode))
            scan_cnt = scan_cnt + 1;
         else
            go_f = 1'b0;
         if (go_b && cell_eq(board, int'(pr) - i * scan_dr,
                             int'(pc) - i * scan_dc, pcode))
            scan_cnt = scan_cnt + 1;
         else
            go_b = 1'b0;
      end
      line_hit = (scan_cnt >= K);
   end

   // ---------------- move legality ----------------
   logic          in_range, occupied, turn_bad, mv_ok;
   logic [IW-1:0] mv_idx;

   always_comb begin
      in_range = (int'(move_row) < N) && (int'(move_col) < N);
      mv_idx   = IW'(int'(move_row) * N + int'(move_col));
      occupied = in_range ? (board[mv_idx] != 2'b00) : 1'b0;
`ifdef TURN_ENFORCE_EN
      turn_bad = (move_player != turn);
`else
      turn_bad = 1'b0;
`endif
      mv_ok    = in_range && !occupied && !turn_bad;
   end

   // ---------------- read port address ----------------
   logic          rd_in;
   logic [IW-1:0] rd_idx;

   always_comb begin
      rd_in  = (int'(rd_row) < N) && (int'(rd_col) < N);
      rd_idx = IW'(int'(rd_row) * N + int'(rd_col));
   end

   // ---------------- turn FSM and board ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         board        <= '0;
         pr           <= '0;
         pc           <= '0;
         pcode        <= 2'b00;
         dir          <= 2'd0;
         hit          <= 1'b0;
         move_ready   <= 1'b1;
         move_illegal <= 1'b0;
         result_valid <= 1'b0;
         win          <= 1'b0;
         winner       <= 2'b00;
         draw         <= 1'b0;
         turn         <= 1'b0;
         move_count   <= 8'd0;
         rd_cell      <= 2'b00;
      end else begin
         move_illegal <= 1'b0;
         result_valid <= 1'b0;
         rd_cell      <= rd_in ? board[rd_idx] : 2'b00;

         if (new_game) begin
            // Overrides everything, including a move presented this cycle.
            state      <= IDLE;
            board      <= '0;
            dir        <= 2'd0;
            hit        <= 1'b0;
            move_ready <= 1'b1;
            win        <= 1'b0;
            winner     <= 2'b00;
            draw       <= 1'b0;
            turn       <= 1'b0;
            move_count <= 8'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (move_valid) begin
                     if (mv_ok) begin
                        board[mv_idx] <= {move_player, ~move_player};
                        pr            <= move_row;
                        pc            <= move_col;
                        pcode         <= {move_player, ~move_player};
                        move_count    <= move_count + 8'd1;
                        dir           <= 2'd0;
                        hit           <= 1'b0;
                        move_ready    <= 1'b0;
                        state         <= CHECK;
                     end else begin
                        move_illegal  <= 1'b1;
                     end
                  end
               end
               // Requests during CHECK are simply not accepted (ready low).
               CHECK: begin
                  hit <= hit | line_hit;
                  dir <= dir + 2'd1;
                  if (dir == 2'd3) begin
                     result_valid <= 1'b1;
                     if (hit | line_hit) begin
                        win    <= 1'b1;
                        winner <= pcode;
                        state  <= OVER;
                     end else if (move_count == 8'(CELLS)) begin
                        draw   <= 1'b1;
                        state  <= OVER;
                     end else begin
                        turn       <= ~turn;
                        move_ready <= 1'b1;
                        state      <= IDLE;
                     end
                  end
               end
               // Game finished: any further move is reported as illegal.
               OVER: begin
                  if (move_valid) move_illegal <= 1'b1;
               end
               default: begin
                  state      <= IDLE;
                  move_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nxn_game_engine.sv
// Bench for nxn_game_engine: one 3x3/K=3 instance and one 5x5/K=4 instance.
// A reference model (brute-force line search over the whole board) pushes
// the expected outcome of each move into a queue; the scenario pops it when
// the DUT reports result_valid or move_illegal.
module tb_nxn_game_engine;

   typedef struct packed {
      logic       ill;
      logic       rv;
      logic       win;
      logic [1:0] winner;
      logic       draw;
      logic       turn;
      logic [7:0] cnt;
      logic       rdy1;     // move_ready the cycle after the request edge
      logic       rdy_end;  // move_ready when the response is seen
      logic [3:0] lat;      // cycles from request edge to response
   } res_t;

   logic clock = 1'b0, reset = 1'b0, new_game = 1'b0;
   always #5 clock = ~clock;

   // 3x3 instance
   logic       a_mv = 0, a_mp = 0, a_rdy, a_ill, a_rv, a_win, a_draw, a_turn;
   logic [1:0] a_mr = 0, a_mc = 0, a_rr = 0, a_rc = 0, a_wnr, a_rd;
   logic [7:0] a_cnt;
   // 5x5 instance
   logic       b_mv = 0, b_mp = 0, b_rdy, b_ill, b_rv, b_win, b_draw, b_turn;
   logic [2:0] b_mr = 0, b_mc = 0, b_rr = 0, b_rc = 0;
   logic [1:0] b_wnr, b_rd;
   logic [7:0] b_cnt;

   nxn_game_engine #(.N(3), .K(3)) dut_a (
      .clock(clock), .reset(reset), .new_game(new_game),
      .move_valid(a_mv), .move_player(a_mp), .move_row(a_mr), .move_col(a_mc),
      .move_ready(a_rdy), .move_illegal(a_ill), .result_valid(a_rv),
      .win(a_win), .winner(a_wnr), .draw(a_draw), .turn(a_turn),
      .move_count(a_cnt), .rd_row(a_rr), .rd_col(a_rc), .rd_cell(a_rd));

   nxn_game_engine #(.N(5), .K(4)) dut_b (
      .clock(clock), .reset(reset), .new_game(new_game),
      .move_valid(b_mv), .move_player(b_mp), .move_row(b_mr), .move_col(b_mc),
      .move_ready(b_rdy), .move_illegal(b_ill), .result_valid(b_rv),
      .win(b_win), .winner(b_wnr), .draw(b_draw), .turn(b_turn),
      .move_count(b_cnt), .rd_row(b_rr), .rd_col(b_rc), .rd_cell(b_rd));

   int tests = 0, fails = 0;
   res_t exp_q[$];

   // ---------------- reference model ----------------
   int         mb[15][15];
   int         mN, mK, mcnt;
   bit         mturn, mover, mwin, mdraw, menf;
   logic [1:0] mwnr;

   task automatic model_reset(input int n, input int k);
      mN = n; mK = k; mcnt = 0;
      mturn = 0; mover = 0; mwin = 0; mdraw = 0; mwnr = 2'b00;
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 15; c++) mb[r][c] = 0;
   endtask

   // Any K consecutive cells of 'code' anywhere on the board.
   function automatic bit any_run(input int code);
      for (int r = 0; r < mN; r++)
         for (int c = 0; c < mN; c++)
            for (int d = 0; d < 4; d++) begin
               int dr, dc; bit ok;
               dr = (d == 0) ? 0 : 1;
               dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
               ok = 1;
               for (int i = 0; i < mK; i++) begin
                  int rr, cc;
                  rr = r + i * dr; cc = c + i * dc;
                  if (rr < 0 || rr >= mN || cc < 0 || cc >= mN) ok = 0;
                  else if (mb[rr][cc] != code) ok = 0;
               end
               if (ok) return 1;
            end
      return 0;
   endfunction

   task automatic model_move(input int p, input int r, input int c, output res_t e);
      e = '0;
      if (mover || r >= mN || c >= mN || mb[r][c] != 0 || (menf && p != int'(mturn))) begin
         e.ill = 1; e.lat = 4'd1; e.rdy1 = !mover; e.rdy_end = !mover;
      end else begin
         mb[r][c] = p + 1;
         mcnt++;
         if (any_run(p + 1)) begin mwin = 1; mwnr = 2'(p + 1); mover = 1; end
         else if (mcnt == mN * mN) begin mdraw = 1; mover = 1; end
         else mturn = !mturn;
         e.rv = 1; e.lat = 4'd5; e.rdy1 = 0; e.rdy_end = !mover;
      end
      e.win = mwin; e.winner = mwnr; e.draw = mdraw; e.turn = mturn; e.cnt = 8'(mcnt);
   endtask

   // ---------------- stimulus ----------------
   // Present one move for one edge and wait (bounded) for the response.
   task automatic drive(input int sel, input int p, input int r, input int c, output res_t o);
      bit got;
      o = '0; got = 0;
      if (sel == 0) begin a_mv = 1; a_mp = p[0]; a_mr = r[1:0]; a_mc = c[1:0]; end
      else          begin b_mv = 1; b_mp = p[0]; b_mr = r[2:0]; b_mc = c[2:0]; end
      @(posedge clock); #1;
      a_mv = 0; b_mv = 0;
      o.rdy1 = (sel == 0) ? a_rdy : b_rdy;
      o.lat  = 4'hF;
      for (int i = 1; i <= 10 && !got; i++) begin
         if (sel == 0 ? (a_ill | a_rv) : (b_ill | b_rv)) begin
            got = 1; o.lat = 4'(i);
            if (sel == 0) begin
               o.ill = a_ill; o.rv = a_rv; o.win = a_win; o.winner = a_wnr;
               o.draw = a_draw; o.turn = a_turn; o.cnt = a_cnt; o.rdy_end = a_rdy;
            end else begin
               o.ill = b_ill; o.rv = b_rv; o.win = b_win; o.winner = b_wnr;
               o.draw = b_draw; o.turn = b_turn; o.cnt = b_cnt; o.rdy_end = b_rdy;
            end
         end else begin
            @(posedge clock); #1;
         end
      end
   endtask

   // Move encoded as player*256 + row*16 + col; expectation goes to the queue.
   task automatic play(input int sel, input int code, output res_t o);
      res_t e;
      model_move(code >> 8, (code >> 4) & 15, code & 15, e);
      exp_q.push_back(e);
      drive(sel, code >> 8, (code >> 4) & 15, code & 15, o);
   endtask

   task automatic do_new_game(input int n, input int k);
      new_game = 1;
      @(posedge clock); #1;
      new_game = 0;
      model_reset(n, k);
   endtask

   task automatic rd_a(input int r, input int c, output logic [1:0] v);
      a_rr = 2'(r); a_rc = 2'(c);
      @(posedge clock); #1;
      v = a_rd;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      reset = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1;
      @(posedge clock); #1;
      tests++;
      if ({a_rdy, a_ill, a_rv, a_win, a_wnr, a_draw, a_turn, a_cnt, a_rd} !== 18'h20000) begin
         fails++; $display("FAIL reset_a: got %h want %h",
            {a_rdy, a_ill, a_rv, a_win, a_wnr, a_draw, a_turn, a_cnt, a_rd}, 18'h20000);
      end
      tests++;
      if ({b_rdy, b_ill, b_rv, b_win, b_wnr, b_draw, b_turn, b_cnt, b_rd} !== 18'h20000) begin
         fails++; $display("FAIL reset_b: got %h want %h",
            {b_rdy, b_ill, b_rv, b_win, b_wnr, b_draw, b_turn, b_cnt, b_rd}, 18'h20000);
      end
   endtask

   task automatic test_win;
      int   seq[6] = '{'h000, 'h110, 'h001, 'h111, 'h002, 'h122};
      res_t o, e;
      do_new_game(3, 3);
      foreach (seq[i]) begin
         play(0, seq[i], o);
         e = exp_q.pop_front();
         tests++;
         if (o !== e) begin fails++; $display("FAIL win_seq move %0d: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_illegal;
      int         seq[3] = '{'h000, 'h100, 'h130};
      res_t       o, e;
      logic [1:0] v;
      do_new_game(3, 3);
      foreach (seq[i]) begin
         play(0, seq[i], o);
         e = exp_q.pop_front();
         tests++;
         if (o !== e) begin fails++; $display("FAIL illegal move %0d: got %h want %h", i, o, e); end
      end
      rd_a(0, 0, v);
      tests++;
      if (v !== 2'b01) begin fails++; $display("FAIL rd_cell(0,0): got %b want 01", v); end
      rd_a(3, 0, v);
      tests++;
      if (v !== 2'b00) begin fails++; $display("FAIL rd_cell out of range: got %b want 00", v); end
   endtask

   task automatic test_draw;
      int   seq[9] = '{'h000, 'h101, 'h002, 'h111, 'h010, 'h112, 'h021, 'h120, 'h022};
      res_t o, e;
      do_new_game(3, 3);
      foreach (seq[i]) begin
         play(0, seq[i], o);
         e = exp_q.pop_front();
         tests++;
         if (o !== e) begin fails++; $display("FAIL draw move %0d: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_anti_diag_5x5;
      int   seq[8] = '{'h000, 'h104, 'h001, 'h113, 'h002, 'h131, 'h040, 'h122};
      res_t o, e;
      do_new_game(5, 4);
      foreach (seq[i]) begin
         play(1, seq[i], o);
         e = exp_q.pop_front();
         tests++;
         if (o !== e) begin fails++; $display("FAIL k4_diag move %0d: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_new_game_mid_check;
      logic [1:0] v;
      bit         seen;
      do_new_game(3, 3);
      a_mv = 1; a_mp = 0; a_mr = 0; a_mc = 0;
      @(posedge clock); #1;               // accepted at this edge (t)
      a_mv = 0;
      @(posedge clock); #1;               // now in cycle t+2
      new_game = 1; a_mv = 1; a_mp = 1; a_mr = 1; a_mc = 1;
      @(posedge clock); #1;
      new_game = 0; a_mv = 0;
      tests++;
      if ({a_rdy, a_ill, a_rv, a_win, a_draw, a_turn, a_cnt} !== {6'b100000, 8'd0}) begin
         fails++; $display("FAIL new_game_mid_check: got %h want %h",
            {a_rdy, a_ill, a_rv, a_win, a_draw, a_turn, a_cnt}, {6'b100000, 8'd0});
      end
      seen = 0;
      repeat (6) begin @(posedge clock); #1; if (a_rv | a_ill) seen = 1; end
      tests++;
      if (seen !== 1'b0) begin fails++; $display("FAIL new_game_no_result: got pulse=%0b want 0", seen); end
      rd_a(0, 0, v);
      tests++;
      if (v !== 2'b00) begin fails++; $display("FAIL new_game_cleared(0,0): got %b want 00", v); end
      rd_a(1, 1, v);
      tests++;
      if (v !== 2'b00) begin fails++; $display("FAIL new_game_dropped(1,1): got %b want 00", v); end
      model_reset(3, 3);
   endtask

   task automatic test_reset_mid_check;
      logic [1:0] v;
      bit         seen;
      do_new_game(3, 3);
      a_mv = 1; a_mp = 0; a_mr = 1; a_mc = 1;
      @(posedge clock); #1;
      a_mv = 0;
      @(posedge clock); #1;
      reset = 0;
      #1;
      tests++;
      if ({a_rdy, a_ill, a_rv, a_win, a_wnr, a_draw, a_turn, a_cnt, a_rd} !== 18'h20000) begin
         fails++; $display("FAIL reset_mid_check: got %h want %h",
            {a_rdy, a_ill, a_rv, a_win, a_wnr, a_draw, a_turn, a_cnt, a_rd}, 18'h20000);
      end
      @(posedge clock); #1;
      reset = 1;
      seen = 0;
      repeat (6) begin @(posedge clock); #1; if (a_rv) seen = 1; end
      tests++;
      if (seen !== 1'b0) begin fails++; $display("FAIL reset_no_result: got pulse=%0b want 0", seen); end
      rd_a(1, 1, v);
      tests++;
      if (v !== 2'b00) begin fails++; $display("FAIL reset_board(1,1): got %b want 00", v); end
      model_reset(3, 3);
   endtask

   task automatic test_back_to_back;
      int   seq[2] = '{'h000, 'h011};
      res_t o, e;
      do_new_game(3, 3);
      foreach (seq[i]) begin
         play(0, seq[i], o);
         e = exp_q.pop_front();
         tests++;
         if (o !== e) begin fails++; $display("FAIL same_player move %0d: got %h want %h", i, o, e); end
      end
   endtask

   initial begin
`ifdef TURN_ENFORCE_EN
      menf = 1;
`else
      menf = 0;
`endif
      model_reset(3, 3);
      test_reset;
      test_win;
      test_illegal;
      test_draw;
      test_anti_diag_5x5;
      test_new_game_mid_check;
      test_reset_mid_check;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
